// File: rtl/multicore_io_hub_if.sv
// Bus bundle between the multicore I/O hub and its sample source, result sink and core array.
interface multicore_io_hub_if #(
   parameter int unsigned N_CORES = 57,
   parameter int unsigned IN_W    = 19,
   parameter int unsigned OUT_W   = 28,
   parameter int unsigned ID_W    = 6
);
   logic [IN_W-1:0]          s_in_data;
   logic                     s_in_valid;
   logic                     s_in_ready;
   logic [N_CORES-1:0]       core_req;
   logic [IN_W-1:0]          core_in_data;
   logic [N_CORES-1:0]       core_in_ack;
   logic [N_CORES*OUT_W-1:0] core_out_data;
   logic [N_CORES-1:0]       core_out_en;
   logic [N_CORES-1:0]       core_out_busy;
   logic [OUT_W-1:0]         m_out_data;
   logic [ID_W-1:0]          m_out_id;
   logic                     m_out_valid;
   logic                     m_out_ready;
   logic [15:0]              drop_cnt;
   logic                     overflow;

   // Environment side: sample source, core array and result sink.
   modport master (
      output s_in_data, s_in_valid, core_req, core_out_data, core_out_en, m_out_ready,
      input  s_in_ready, core_in_data, core_in_ack, core_out_busy,
             m_out_data, m_out_id, m_out_valid, drop_cnt, overflow
   );

   // Hub side.
   modport slave (
      input  s_in_data, s_in_valid, core_req, core_out_data, core_out_en, m_out_ready,
      output s_in_ready, core_in_data, core_in_ack, core_out_busy,
             m_out_data, m_out_id, m_out_valid, drop_cnt, overflow
   );
endinterface

// File: rtl/multicore_io_hub.sv
// I/O concentrator for the multicore array: broadcasts input samples to requesting cores and
// collects per-core results through holding slots and a round-robin arbiter into a tagged FIFO.
module multicore_io_hub #(
   parameter int unsigned N_CORES    = 57,
   parameter int unsigned IN_W       = 19,
   parameter int unsigned OUT_W      = 28,
   parameter int unsigned ID_W       = 6,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   multicore_io_hub_if.slave bus
);
   localparam int unsigned IDX_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
   localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W    = PTR_W + 1;
   localparam int unsigned POP_W    = $clog2(N_CORES + 1);
   localparam int unsigned SUM_W    = ID_W + 1;
   localparam int unsigned DCNT_W   = 16;
   localparam logic [DCNT_W-1:0] DROP_MAX = '1;

   // Input broadcast state
   logic [IN_W-1:0]    core_in_data_q, core_in_data_d;
   logic [N_CORES-1:0] core_in_ack_q,  core_in_ack_d;

   // Holding slots and arbiter pointer
   logic [OUT_W-1:0]   slot_data_q [N_CORES];
   logic [N_CORES-1:0] slot_busy_q, slot_busy_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;

   // Output FIFO
   logic [OUT_W-1:0]   fifo_data_q [FIFO_DEPTH];
   logic [ID_W-1:0]    fifo_id_q   [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q,  count_d;

   // Drop accounting
   logic [DCNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic               overflow_q, overflow_d;

   // Combinational helpers
   logic               fetch;
   logic               pop;
   logic               push;
   logic               can_push;
   logic [SUM_W-1:0]   cand;
   logic               grant_vld;
   logic [ID_W-1:0]    grant_idx;
   logic [N_CORES-1:0] grant;
   logic [N_CORES-1:0] slot_load;
   logic [N_CORES-1:0] drops;
   logic [POP_W-1:0]   drop_num;
   logic [DCNT_W:0]    drop_sum;

   // Next-state logic for broadcast, arbitration, slots, FIFO pointers and drop counter
   always_comb begin
      core_in_data_d = core_in_data_q;
      core_in_ack_d  = '0;
      rr_ptr_d       = rr_ptr_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      count_d        = count_q;
      overflow_d     = overflow_q;
      cand           = '0;
      grant_vld      = 1'b0;
      grant_idx      = '0;
      grant          = '0;
      drop_num       = '0;

      fetch = (|bus.core_req) & bus.s_in_valid;
      if (fetch) begin
         core_in_data_d = bus.s_in_data;
         core_in_ack_d  = bus.core_req;
      end

      pop      = (count_q != '0) & bus.m_out_ready;
      can_push = (count_q < CNT_W'(FIFO_DEPTH)) | pop;

      // First occupied slot at or after the RR pointer, wrapping at N_CORES
      for (int unsigned k = 0; k < N_CORES; k++) begin
         cand = {1'b0, rr_ptr_q} + SUM_W'(k);
         if (cand >= SUM_W'(N_CORES)) begin
            cand = cand - SUM_W'(N_CORES);
         end
         if (!grant_vld && can_push && slot_busy_q[IDX_W'(cand)]) begin
            grant_vld = 1'b1;
            grant_idx = ID_W'(cand);
         end
      end
      if (grant_vld) begin
         grant[IDX_W'(grant_idx)] = 1'b1;
         rr_ptr_d = (grant_idx == ID_W'(N_CORES - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      push = grant_vld;

      // A granted slot frees up this cycle, so a new result may reload it
      slot_load   = bus.core_out_en & (~slot_busy_q | grant);
      drops       = bus.core_out_en & slot_busy_q & ~grant;
      slot_busy_d = slot_load | (slot_busy_q & ~grant);

      for (int unsigned i = 0; i < N_CORES; i++) begin
         drop_num = drop_num + POP_W'(drops[i]);
      end
      drop_sum   = {1'b0, drop_cnt_q} + (DCNT_W+1)'(drop_num);
      drop_cnt_d = drop_sum[DCNT_W] ? DROP_MAX : drop_sum[DCNT_W-1:0];
      if (|drops) begin
         overflow_d = 1'b1;
      end

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control and status registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_in_data_q <= '0;
         core_in_ack_q  <= '0;
         slot_busy_q    <= '0;
         rr_ptr_q       <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         drop_cnt_q     <= '0;
         overflow_q     <= 1'b0;
      end else begin
         core_in_data_q <= core_in_data_d;
         core_in_ack_q  <= core_in_ack_d;
         slot_busy_q    <= slot_busy_d;
         rr_ptr_q       <= rr_ptr_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         drop_cnt_q     <= drop_cnt_d;
         overflow_q     <= overflow_d;
      end
   end

   // Holding slot payloads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_CORES; i++) begin
            slot_data_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < N_CORES; i++) begin
            if (slot_load[i]) begin
               slot_data_q[i] <= bus.core_out_data[i*OUT_W +: OUT_W];
            end
         end
      end
   end

   // FIFO storage; cleared on reset so the idle head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
            fifo_data_q[j] <= '0;
            fifo_id_q[j]   <= '0;
         end
      end else if (push) begin
         fifo_data_q[wr_ptr_q] <= slot_data_q[IDX_W'(grant_idx)];
         fifo_id_q[wr_ptr_q]   <= grant_idx;
      end
   end

   assign bus.s_in_ready    = |bus.core_req;
   assign bus.core_in_data  = core_in_data_q;
   assign bus.core_in_ack   = core_in_ack_q;
   assign bus.core_out_busy = slot_busy_q;
   assign bus.m_out_data    = fifo_data_q[rd_ptr_q];
   assign bus.m_out_id      = fifo_id_q[rd_ptr_q];
   assign bus.m_out_valid   = (count_q != '0);
   assign bus.drop_cnt      = drop_cnt_q;
   assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_multicore_io_hub.sv
// Self-checking bench for multicore_io_hub: directed scenarios plus random traffic,
// all compared against a queue-based behavioural model.
module tb_multicore_io_hub;
   localparam int unsigned N_CORES    = 57;
   localparam int unsigned IN_W       = 19;
   localparam int unsigned OUT_W      = 28;
   localparam int unsigned ID_W       = 6;
   localparam int unsigned FIFO_DEPTH = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicore_io_hub_if #(.N_CORES(N_CORES), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)) bus ();

   multicore_io_hub #(
      .N_CORES(N_CORES), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [IN_W-1:0]         m_in_data;
   logic [N_CORES-1:0]      m_ack;
   bit                      m_busy [N_CORES];
   logic [OUT_W-1:0]        m_slot [N_CORES];
   int                      m_ptr;
   logic [ID_W+OUT_W-1:0]   m_fifo [$];
   int                      m_drops;
   bit                      m_ovf;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expd);
      checks++;
      if (act !== expd) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, expd, $time);
      end
   endtask

   task automatic model_reset();
      m_in_data = '0;
      m_ack     = '0;
      m_ptr     = 0;
      m_drops   = 0;
      m_ovf     = 1'b0;
      m_fifo.delete();
      for (int i = 0; i < N_CORES; i++) begin
         m_busy[i] = 1'b0;
         m_slot[i] = '0;
      end
   endtask

   // One clock edge of the hub, described as queue and array operations
   task automatic model_step();
      bit pop;
      bit space;
      int g;
      logic [ID_W+OUT_W-1:0] dummy;
      pop   = (m_fifo.size() > 0) && bus.m_out_ready;
      space = (m_fifo.size() < FIFO_DEPTH) || pop;
      g = -1;
      if (space) begin
         for (int k = 0; k < N_CORES; k++) begin
            int c;
            c = (m_ptr + k) % N_CORES;
            if (g < 0 && m_busy[c]) g = c;
         end
      end
      if (pop) dummy = m_fifo.pop_front();
      if (g >= 0) begin
         m_fifo.push_back({ID_W'(g), m_slot[g]});
         m_busy[g] = 1'b0;
         m_ptr = (g + 1) % N_CORES;
      end
      for (int i = 0; i < N_CORES; i++) begin
         if (bus.core_out_en[i]) begin
            if (m_busy[i]) begin
               if (m_drops < 65535) m_drops++;
               m_ovf = 1'b1;
            end else begin
               m_busy[i] = 1'b1;
               m_slot[i] = bus.core_out_data[i*OUT_W +: OUT_W];
            end
         end
      end
      if ((|bus.core_req) && bus.s_in_valid) begin
         m_in_data = bus.s_in_data;
         m_ack     = bus.core_req;
      end else begin
         m_ack = '0;
      end
   endtask

   task automatic compare_all();
      logic [N_CORES-1:0]    bv;
      logic [ID_W+OUT_W-1:0] head;
      for (int i = 0; i < N_CORES; i++) bv[i] = m_busy[i];
      check("core_in_data", 64'(bus.core_in_data), 64'(m_in_data));
      check("core_in_ack", 64'(bus.core_in_ack), 64'(m_ack));
      check("core_out_busy", 64'(bus.core_out_busy), 64'(bv));
      check("m_out_valid", 64'(bus.m_out_valid), 64'(m_fifo.size() != 0));
      if (m_fifo.size() != 0) begin
         head = m_fifo[0];
         check("m_out_data", 64'(bus.m_out_data), 64'(head[OUT_W-1:0]));
         check("m_out_id", 64'(bus.m_out_id), 64'(head[ID_W+OUT_W-1:OUT_W]));
      end
      check("drop_cnt", 64'(bus.drop_cnt), 64'(m_drops));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
   endtask

   // Called at a falling edge with inputs already set; returns at the next falling edge
   task automatic cycle();
      #1;
      check("s_in_ready", 64'(bus.s_in_ready), 64'(|bus.core_req));
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle_inputs();
      bus.s_in_data     = '0;
      bus.s_in_valid    = 1'b0;
      bus.core_req      = '0;
      bus.core_out_data = '0;
      bus.core_out_en   = '0;
      bus.m_out_ready   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) cycle();
      rst_n = 1'b1;
   endtask

   task automatic present(input int lo, input int hi);
      bus.core_out_en = '0;
      for (int i = lo; i <= hi; i++) begin
         bus.core_out_en[i] = 1'b1;
         bus.core_out_data[i*OUT_W +: OUT_W] = OUT_W'($urandom);
      end
   endtask

   initial begin
      int exp_id;
      int exp_seq [$];
      idle_inputs();
      model_reset();

      // Reset and idle
      repeat (3) cycle();
      rst_n = 1'b1;
      repeat (10) begin
         cycle();
         check("idle_data", 64'(bus.m_out_data), 64'd0);
         check("idle_id", 64'(bus.m_out_id), 64'd0);
      end

      // Sample broadcast and stall
      bus.core_req = '0;
      bus.core_req[0] = 1'b1; bus.core_req[5] = 1'b1; bus.core_req[56] = 1'b1;
      bus.s_in_valid = 1'b1;
      bus.s_in_data  = -19'sd1234;
      cycle();
      check("bcast_ack", 64'(bus.core_in_ack), 64'h0100_0000_0000_0021);
      check("bcast_data", 64'($signed(bus.core_in_data)), 64'(-1234));
      bus.s_in_valid = 1'b0;
      bus.s_in_data  = 19'd777;
      cycle();
      check("stall_ack", 64'(bus.core_in_ack), 64'd0);
      check("stall_data", 64'($signed(bus.core_in_data)), 64'(-1234));
      bus.core_req = '0;

      // Round-robin drain of all cores
      bus.m_out_ready = 1'b1;
      bus.core_out_en = '1;
      for (int i = 0; i < N_CORES; i++)
         bus.core_out_data[i*OUT_W +: OUT_W] = OUT_W'(i*1000 - 20000);
      cycle();
      bus.core_out_en = '0;
      exp_id = 0;
      for (int n = 0; n < N_CORES + 4; n++) begin
         if (bus.m_out_valid) begin
            check("rr_id", 64'(bus.m_out_id), 64'(exp_id));
            check("rr_data", 64'($signed(bus.m_out_data)), 64'(exp_id*1000 - 20000));
            exp_id++;
         end
         cycle();
      end
      check("rr_count", 64'(exp_id), 64'(N_CORES));
      check("rr_drops", 64'(bus.drop_cnt), 64'd0);

      // Backpressure and drop
      do_reset();
      present(0, 19);
      cycle();
      bus.core_out_en = '0;
      repeat (18) cycle();
      present(19, 19);
      cycle();
      bus.core_out_en = '0;
      cycle();
      check("bp_drop", 64'(bus.drop_cnt), 64'd1);
      check("bp_ovf", 64'(bus.overflow), 64'd1);
      check("bp_busy", 64'(bus.core_out_busy), 64'h000F_0000);
      check("bp_head", 64'(bus.m_out_id), 64'd0);
      bus.m_out_ready = 1'b1;
      exp_id = 0;
      for (int n = 0; n < 26; n++) begin
         if (bus.m_out_valid) begin
            check("bp_order", 64'(bus.m_out_id), 64'(exp_id));
            exp_id++;
         end
         cycle();
      end
      check("bp_count", 64'(exp_id), 64'd20);

      // Full FIFO with a simultaneous pop and push from slot 3
      do_reset();
      present(0, 15);
      cycle();
      bus.core_out_en = '0;
      repeat (17) cycle();
      present(3, 3);
      cycle();
      bus.core_out_en = '0;
      check("full_busy", 64'(bus.core_out_busy), 64'h8);
      bus.m_out_ready = 1'b1;
      cycle();
      bus.m_out_ready = 1'b0;
      cycle();
      check("full_busy_clr", 64'(bus.core_out_busy), 64'd0);
      for (int i = 1; i < 16; i++) exp_seq.push_back(i);
      exp_seq.push_back(3);
      bus.m_out_ready = 1'b1;
      exp_id = 0;
      for (int n = 0; n < 20; n++) begin
         if (bus.m_out_valid) begin
            if (exp_id < 16) check("full_order", 64'(bus.m_out_id), 64'(exp_seq[exp_id]));
            exp_id++;
         end
         cycle();
      end
      check("full_count", 64'(exp_id), 64'd16);
      check("full_drops", 64'(bus.drop_cnt), 64'd0);

      // Asynchronous reset mid-stream
      do_reset();
      present(0, 7);
      cycle();
      bus.core_out_en = '0;
      repeat (10) cycle();
      check("pre_rst_valid", 64'(bus.m_out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 64'(bus.m_out_valid), 64'd0);
      check("async_busy", 64'(bus.core_out_busy), 64'd0);
      model_reset();
      @(negedge clk);
      cycle();
      rst_n = 1'b1;
      bus.m_out_ready = 1'b1;
      present(0, N_CORES - 1);
      cycle();
      bus.core_out_en = '0;
      cycle();
      check("post_rst_first", 64'(bus.m_out_id), 64'd0);
      check("post_rst_drops", 64'(bus.drop_cnt), 64'd0);
      repeat (N_CORES) cycle();

      // Random traffic
      for (int n = 0; n < 2500; n++) begin
         bus.s_in_valid = 1'($urandom_range(0, 1));
         bus.s_in_data  = IN_W'($urandom);
         for (int i = 0; i < N_CORES; i++) begin
            bus.core_req[i]    = ($urandom_range(0, 7) == 0);
            bus.core_out_en[i] = ($urandom_range(0, 15) == 0);
            bus.core_out_data[i*OUT_W +: OUT_W] = OUT_W'($urandom);
         end
         if ((n / 500) % 2 == 0) bus.m_out_ready = ($urandom_range(0, 3) != 0);
         else bus.m_out_ready = ($urandom_range(0, 3) == 0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicore_io_hub.md
Name: multicore_io_hub

Overview:
- Parametrised input/output concentrator for the N-core Taylor-network multicore array.
- Input side: broadcasts one 19-bit signed sample stream to all cores and acknowledges each core that requests the sample.
- Output side: captures each core's 28-bit result into a per-core holding slot, then drains the slots round-robin into a tagged FIFO with a valid/ready output.
- Adds per-core backpressure and drop accounting. Sits between the sample source/sink and the core array.

Parameters:
- N_CORES, 57, number of cores served.
- IN_W, 19, signed input sample width.
- OUT_W, 28, signed core result width.
- ID_W, 6, core index tag width; must satisfy 2^ID_W >= N_CORES.
- FIFO_DEPTH, 16, output FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_in_data  in  IN_W  upstream sample, signed.
- s_in_valid  in  1  upstream sample valid.
- s_in_ready  out  1  sample consumed this cycle.
- core_req  in  N_CORES  bit i: core i requests the next sample.
- core_in_data  out  IN_W  broadcast sample register.
- core_in_ack  out  N_CORES  bit i: 1-cycle pulse, core_in_data is valid for core i.
- core_out_data  in  N_CORES*OUT_W  core i result in bits [i*OUT_W +: OUT_W].
- core_out_en  in  N_CORES  bit i: core i presents a result this cycle.
- core_out_busy  out  N_CORES  bit i: core i's holding slot is occupied.
- m_out_data  out  OUT_W  FIFO head result.
- m_out_id  out  ID_W  FIFO head core index.
- m_out_valid  out  1  FIFO not empty.
- m_out_ready  in  1  sink accepts the head.
- drop_cnt  out  16  saturating count of dropped results.
- overflow  out  1  sticky; set on the first drop.

Behaviour:
- Reset (async assert, synchronous release): core_in_data=0, core_in_ack=0, holding slots empty (core_out_busy=0), RR pointer=0, FIFO empty (m_out_valid=0, m_out_data=0, m_out_id=0), drop_cnt=0, overflow=0. Reset asserted mid-operation discards all pending and queued data immediately.
- Input side:
  - s_in_ready = |core_req (combinational).
  - Fetch = s_in_ready & s_in_valid. On a fetch edge: core_in_data <= s_in_data, core_in_ack <= core_req. Otherwise core_in_ack <= 0 and core_in_data holds.
  - Latency from request to ack: 1 cycle. Requests made in the same cycle share one sample.
  - If core_req is nonzero and s_in_valid=0: stall, ack stays 0. Cores keep requesting.
- Holding slots:
  - Slot i loads {core_out_data[i], i} when core_out_en[i]=1 and either slot i is empty or slot i is granted in this cycle. A grant and a reload in the same cycle are legal; the slot stays occupied.
  - If core_out_en[i]=1 while slot i is occupied and not granted, the result is dropped.
  - drop_cnt += popcount(drops) per cycle, saturating at 16'hFFFF. overflow is set and held until reset.
  - core_out_busy[i] = slot i occupied (registered).
- Arbiter:
  - Grants at most one occupied slot per cycle, and only when the FIFO can accept (count<FIFO_DEPTH, or full with a pop this cycle).
  - Search starts at the RR pointer and wraps from N_CORES-1 to 0.
  - On a grant, pointer <= grant+1, wrapping to 0 past N_CORES-1. With no grant, the pointer holds.
- FIFO:
  - First-word fall-through; m_out_* reflect the head whenever m_out_valid=1.
  - Pop = m_out_valid & m_out_ready.
  - Simultaneous push and pop at full: both occur, count unchanged. Pop at empty: ignored.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- Latency: core_out_en sampled at edge k → slot occupied after k → granted and pushed at edge k+1 → m_out_valid=1 after k+1 (2 edges, when uncontended).
- Arithmetic: data passes unmodified, sign preserved, no width change. m_out_id is the core index zero-extended to ID_W.

Test Plan:
- Reset/idle: rst_n low 3 cycles then high, all inputs 0 → every output 0 and m_out_valid=0 for 10 cycles.
- Sample broadcast: core_req=bits{0,5,56}, s_in_valid=1, s_in_data=-19'sd1234 → s_in_ready=1 that cycle. Next cycle core_in_ack has exactly bits 0,5,56 set and core_in_data=-1234. With s_in_valid=0 and a request pending → no ack, core_in_data holds.
- Round-robin fairness: all 57 cores assert core_out_en for one cycle with core_out_data[i]=i*1000-20000, m_out_ready=1 → m_out_id sequence 0,1,…,56, each with the matching data, one per cycle, drop_cnt=0.
- Backpressure/drop: m_out_ready=0, FIFO_DEPTH=16. Cores 0..19 each present once, then core 19 presents again → FIFO holds ids 0..15, core_out_busy has bits 16..19 set, drop_cnt=1, overflow=1. Release ready → ids 16..19 follow in order.
- Simultaneous full push/pop: FIFO full, slot 3 occupied, m_out_ready=1 → one pop and one push (id 3) in the same cycle, count stays 16, no data loss.
- Async reset mid-stream: assert rst_n low between edges while FIFO holds 8 entries → m_out_valid drops to 0 without waiting for a clock edge. After release, the pointer starts at 0 and drop_cnt=0.
